// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - two-master data memory arbiter with size/lane handling
module dm_access_arbiter #(
  parameter int AW    = 11,
  parameter bit RR_EN = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    m_req,
  input  logic [1:0]    m_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [31:0]   m1_wdata,
  input  logic [1:0]    m0_size,
  input  logic [1:0]    m1_size,
  input  logic [1:0]    m_sext,
  output logic [1:0]    m_ack,
  output logic [1:0]    m_err,
  output logic [31:0]   m_rdata,
  output logic [AW-1:0] dm_a,
  output logic          dm_we,
  output logic [31:0]   dm_wd,
  output logic [3:0]    dm_be,
  input  logic [31:0]   dm_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = M0, 1 = M1
  logic        last_q, last_d;     // master served most recently
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Live inputs of the granted master
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [1:0]  g_size;
  logic        g_we;
  logic        g_req;
  logic        g_sext;
  logic        in_access;

  assign g_addr    = grant_q ? m1_addr  : m0_addr;
  assign g_wdata   = grant_q ? m1_wdata : m0_wdata;
  assign g_size    = grant_q ? m1_size  : m0_size;
  assign g_we      = m_we[grant_q];
  assign g_req     = m_req[grant_q];
  assign g_sext    = m_sext[grant_q];
  assign in_access = (state_q == S_ACCESS);

  logic        fault;
  logic [3:0]  be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Fault detection, byte-enable generation and load-lane extraction for the granted access
  always_comb begin
    fault   = 1'b0;
    be      = 4'b0000;
    ld_byte = dm_rd[8*g_addr[1:0] +: 8];
    ld_half = dm_rd[16*g_addr[1] +: 16];
    ld_val  = dm_rd;
    case (g_size)
      2'b00: begin
        be     = 4'b0001 << g_addr[1:0];
        ld_val = {{24{g_sext & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        fault  = g_addr[0];
        be     = g_addr[1] ? 4'b1100 : 4'b0011;
        ld_val = {{16{g_sext & ld_half[15]}}, ld_half};
      end
      2'b10: begin
        fault  = (g_addr[1:0] != 2'b00);
        be     = 4'b1111;
        ld_val = dm_rd;
      end
      default: begin
        fault = 1'b1;
        be    = 4'b0000;
      end
    endcase
    if (|g_addr[31:AW+2]) fault = 1'b1;
  end

  // Memory port: only active in ACCESS; a synchronous reset in that cycle kills the write
  always_comb begin
    dm_a  = g_addr[AW+1:2];
    dm_wd = g_wdata;
    dm_be = (in_access && !Reset) ? be : 4'b0000;
    dm_we = in_access && !Reset && g_we && g_req && !fault;
  end

  // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|m_req) begin
          if (m_req == 2'b11) grant_d = RR_EN ? ~last_q : 1'b0;
          else                grant_d = m_req[1];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!g_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
          if (fault) begin
            err_d   = grant_q ? 2'b10 : 2'b01;
            rdata_d = 32'd0;
          end else begin
            ack_d   = grant_q ? 2'b10 : 2'b01;
            rdata_d = ld_val;
          end
        end
      end
      S_RESP: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset leaves M1 as last served so M0 wins the first tie
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_ack   = ack_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - scoreboard bench for dm_access_arbiter
module tb_dm_access_arbiter;
  localparam int AW = 11;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [1:0]    m_req, m_we, m0_size, m1_size, m_sext;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]    m_ack, m_err;
  logic [31:0]   m_rdata;
  logic [AW-1:0] dm_a;
  logic          dm_we;
  logic [31:0]   dm_wd, dm_rd;
  logic [3:0]    dm_be;

  // Second instance with fixed priority, only requested during the contention phase
  logic          fp_en;
  logic [1:0]    fp_req, fp_ack, fp_err;
  logic [31:0]   fp_rdata, fp_dm_wd, fp_dm_rd;
  logic [AW-1:0] fp_dm_a;
  logic          fp_dm_we;
  logic [3:0]    fp_dm_be;

  logic [31:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rd;
    bit          chk_rd;
    int          issue;
  } rsp_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   wd;
  } wr_t;

  rsp_t       exp_q[$];
  wr_t        wr_q[$];
  logic [1:0] fp_q[$];
  int         n_vec = 0;
  int         n_mis = 0;
  int         cyc = 0;

  always #5 Clk = ~Clk;

  assign fp_req   = fp_en ? m_req : 2'b00;
  assign dm_rd    = mem[dm_a];
  assign fp_dm_rd = mem[fp_dm_a];

  dm_access_arbiter #(.AW(AW), .RR_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .m_req(m_req), .m_we(m_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_size(m0_size), .m1_size(m1_size), .m_sext(m_sext),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .dm_a(dm_a), .dm_we(dm_we), .dm_wd(dm_wd), .dm_be(dm_be), .dm_rd(dm_rd)
  );

  dm_access_arbiter #(.AW(AW), .RR_EN(1'b0)) u_fp (
    .Clk(Clk), .Reset(Reset), .m_req(fp_req), .m_we(m_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_size(m0_size), .m1_size(m1_size), .m_sext(m_sext),
    .m_ack(fp_ack), .m_err(fp_err), .m_rdata(fp_rdata),
    .dm_a(fp_dm_a), .dm_we(fp_dm_we), .dm_wd(fp_dm_wd), .dm_be(fp_dm_be), .dm_rd(fp_dm_rd)
  );

  // Memory takes right-aligned write data and places it starting at the lowest enabled lane
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] res;
    int lo;
    res = old;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = wd[8*(i-lo) +: 8];
    return res;
  endfunction

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (dm_we) mem[dm_a] <= merge(mem[dm_a], dm_wd, dm_be);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a response or a memory write
  always @(negedge Clk) begin : mon
    rsp_t e;
    wr_t  w;
    logic [1:0] f;
    if (m_ack != 2'b00 || m_err != 2'b00) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", {28'd0, m_err, m_ack}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ack", {30'd0, m_ack}, {30'd0, e.ack});
        chk("err", {30'd0, m_err}, {30'd0, e.err});
        if (e.chk_rd) chk("rdata", m_rdata, e.rd);
        if (e.issue >= 0) chk("latency", cyc - e.issue, 32'd2);
      end
    end
    if (dm_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", {31'd0, dm_we}, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("dm_a", {{(32-AW){1'b0}}, dm_a}, {{(32-AW){1'b0}}, w.a});
        chk("dm_be", {28'd0, dm_be}, {28'd0, w.be});
        chk("dm_wd", dm_wd, w.wd);
      end
    end
    if (fp_ack != 2'b00 || fp_err != 2'b00) begin
      if (fp_q.size() == 0) chk("fp_unexpected_rsp", {28'd0, fp_err, fp_ack}, 32'd0);
      else begin
        f = fp_q.pop_front();
        chk("fp_ack", {28'd0, fp_err, fp_ack}, {30'd0, f});
      end
    end
  end

  task automatic set_master(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input bit sext);
    if (m == 0) begin
      m_we[0] = we; m0_addr = addr; m0_wdata = wd; m0_size = size; m_sext[0] = sext;
    end else begin
      m_we[1] = we; m1_addr = addr; m1_wdata = wd; m1_size = size; m_sext[1] = sext;
    end
  endtask

  task automatic push_rsp(input int m, input bit err, input bit chk_rd, input logic [31:0] rd, input int issue);
    rsp_t e;
    e.ack    = err ? 2'b00 : (m == 0 ? 2'b01 : 2'b10);
    e.err    = err ? (m == 0 ? 2'b01 : 2'b10) : 2'b00;
    e.rd     = rd;
    e.chk_rd = chk_rd;
    e.issue  = issue;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    wr_t w;
    w.a = a; w.be = be; w.wd = wd;
    wr_q.push_back(w);
  endtask

  task automatic wait_rsp(input int m);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge Clk);
      if (m_ack[m] || m_err[m]) got = 1'b1;
    end
    chk("rsp_timeout", {31'd0, got}, 32'd1);
    m_req[m] = 1'b0;
  endtask

  task automatic xact(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] size, input bit sext, input bit ex_err, input logic [31:0] ex_rd);
    @(posedge Clk); #1;
    set_master(m, we, addr, wd, size, sext);
    push_rsp(m, ex_err, !we || ex_err, ex_rd, cyc);
    m_req[m] = 1'b1;
    wait_rsp(m);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, {30'd0, m_ack}, 32'd0);
    chk({tag, "_err"}, {30'd0, m_err}, 32'd0);
    chk({tag, "_rdata"}, m_rdata, 32'd0);
    chk({tag, "_we"}, {31'd0, dm_we}, 32'd0);
    chk({tag, "_be"}, {28'd0, dm_be}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    Reset = 1'b1; m_req = 2'b11; m_we = 2'b00; m_sext = 2'b00; fp_en = 1'b0;
    m0_addr = 32'd0; m1_addr = 32'd0; m0_wdata = 32'd0; m1_wdata = 32'd0;
    m0_size = 2'b10; m1_size = 2'b10;

    // Reset held with both masters requesting; first grant after release goes to M0
    repeat (2) begin
      @(posedge Clk); @(negedge Clk);
      chk_reset_outputs("reset");
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    push_rsp(0, 1'b0, 1'b1, 32'd0, cyc);
    wait_rsp(0);
    m_req = 2'b00;

    // Word store/load, half store merging into the same word
    push_wr(11'd4, 4'b1111, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'd0);
    xact(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF);
    push_wr(11'd4, 4'b1100, 32'h00001234);
    xact(0, 1'b1, 32'h12, 32'h1234, 2'b01, 1'b0, 1'b0, 32'd0);
    xact(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0, 32'h1234BEEF);

    // Byte and half accesses with sign/zero extension
    push_wr(11'd8, 4'b0010, 32'h00000080);
    xact(1, 1'b1, 32'h21, 32'h80, 2'b00, 1'b0, 1'b0, 32'd0);
    xact(1, 1'b0, 32'h21, 32'd0, 2'b00, 1'b1, 1'b0, 32'hFFFFFF80);
    xact(1, 1'b0, 32'h21, 32'd0, 2'b00, 1'b0, 1'b0, 32'h00000080);
    xact(0, 1'b0, 32'h20, 32'd0, 2'b01, 1'b1, 1'b0, 32'hFFFF8000);
    xact(1, 1'b0, 32'h11, 32'd0, 2'b00, 1'b1, 1'b0, 32'hFFFFFFBE);

    // Faults: misaligned half store, out-of-range, misaligned word, illegal size
    xact(0, 1'b1, 32'h3, 32'hAAAA, 2'b01, 1'b0, 1'b1, 32'd0);
    xact(0, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 1'b0, 32'd0);
    xact(1, 1'b0, 32'h2000, 32'd0, 2'b10, 1'b0, 1'b1, 32'd0);
    xact(0, 1'b0, 32'h12, 32'd0, 2'b10, 1'b0, 1'b1, 32'd0);
    xact(1, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 1'b1, 32'd0);

    // Abort: request withdrawn while in ACCESS
    @(posedge Clk); #1;
    set_master(0, 1'b1, 32'h0, 32'h55, 2'b10, 1'b0);
    m_req[0] = 1'b1;
    @(posedge Clk); #1;
    m_req[0] = 1'b0;
    repeat (3) @(posedge Clk);
    xact(1, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 1'b0, 32'd0);

    // Reset arriving in the ACCESS cycle of a store
    xact(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0, 32'h1234BEEF);
    @(posedge Clk); #1;
    set_master(0, 1'b1, 32'h4, 32'h77, 2'b10, 1'b0);
    m_req[0] = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("midop_rst_we", {31'd0, dm_we}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_req = 2'b00;
    @(negedge Clk);
    chk_reset_outputs("midop_rst");
    xact(0, 1'b0, 32'h4, 32'd0, 2'b10, 1'b0, 1'b0, 32'd0);

    // Contention with both requests held: round-robin vs fixed priority
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    set_master(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
    set_master(1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      push_rsp(0, 1'b0, 1'b1, 32'h1234BEEF, -1);
      push_rsp(1, 1'b0, 1'b1, 32'h00008000, -1);
    end
    for (int i = 0; i < 4; i++) fp_q.push_back(2'b01);
    m_req = 2'b11;
    fp_en = 1'b1;
    k = 0;
    for (int t = 0; t < 40 && k < 4; t++) begin
      @(negedge Clk);
      if (m_ack != 2'b00) k++;
    end
    m_req = 2'b00;
    fp_en = 1'b0;
    chk("contention_acks", k, 32'd4);

    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("exp_q_left", exp_q.size(), 32'd0);
    chk("wr_q_left", wr_q.size(), 32'd0);
    chk("fp_q_left", fp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
